// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared constants, FSM states and helpers for the cache<->RAM block interface
package mem_if_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 20;
  localparam int BLOCKS = 512;
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  function automatic logic [8:0] blk_idx(input logic [ADDR_W-1:0] addr);
    return addr[9:1];
  endfunction
  // every word of the power-up image holds its own word address
  function automatic logic [BLOCKS-1:0][DATA_W-1:0] init_store();
    logic [BLOCKS-1:0][DATA_W-1:0] s;
    for (int b = 0; b < BLOCKS; b++) s[b] = {10'(2 * b + 1), 10'(2 * b)};
    return s;
  endfunction
endpackage

// File: rtl/block_ram_array.sv
// block_ram_array: single-port 512x20 block store, synchronous write, registered read
module block_ram_array
  import mem_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [8:0]        idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [BLOCKS-1:0][DATA_W-1:0] store = init_store();
  always_ff @(posedge clk) begin
    if (we) store[idx] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= store[idx];
  end
endmodule

// File: rtl/mem_block_responder.sv
// mem_block_responder: memory-side responder with posted writes and fixed-latency block reads
module mem_block_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 20,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data_ram_bus,
  output logic              mem_ready,
  output logic              busy,
  output logic              drop_err
);
  import mem_if_pkg::*;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [8:0] idx_q;
  logic [DATA_W-1:0] rd_q;
  logic wr, rd, accept, drop;
  // a held copy of the outstanding read is legal; anything else arriving in WAIT is dropped
  always_comb begin
    accept = state == IDLE && mem_req && !mem_rw;
    wr     = state == IDLE && mem_req && mem_rw;
    rd     = state == WAIT && cnt == 4'd0;
    drop   = state == WAIT && mem_req && (mem_rw || blk_idx(mem_addr) != idx_q);
    nxt    = state == IDLE ? (accept ? WAIT : IDLE) :
             state == WAIT ? (rd ? RESPOND : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      drop_err <= 1'b0;
    end else begin
      state    <= nxt;
      drop_err <= drop;
      if (accept) begin
        cnt   <= 4'(LATENCY - 1);
        idx_q <= blk_idx(mem_addr);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end
  block_ram_array u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr),
    .re   (rd),
    .idx  (state == WAIT ? idx_q : blk_idx(mem_addr)),
    .wdata(mem_data_ram_bus),
    .rdata(rd_q)
  );
  assign mem_ready = state == RESPOND;
  assign busy = state != IDLE;
  assign mem_data_ram_bus = mem_ready ? rd_q : 'z;
endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: randomized protocol bench against an array model of the block store
module tb_mem_block_responder;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic req = 1'b0, rw = 1'b0, drv_en = 1'b0;
  logic [9:0] addr = '0;
  logic [19:0] drv = '0;
  wire [19:0] bus;
  logic ready, busy, drop;
  logic req1 = 1'b0, rw1 = 1'b0, drv_en1 = 1'b0;
  logic [9:0] addr1 = '0;
  logic [19:0] drv1 = '0;
  wire [19:0] bus1;
  logic ready1, busy1, drop1;
  logic [19:0] model [512];
  int n_checks = 0, n_errors = 0;
  assign bus = drv_en ? drv : 'z;
  assign bus1 = drv_en1 ? drv1 : 'z;
  always #5 clk = ~clk;
  mem_block_responder #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_rw(rw), .mem_addr(addr),
    .mem_data_ram_bus(bus), .mem_ready(ready), .busy(busy), .drop_err(drop)
  );
  mem_block_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_rw(rw1), .mem_addr(addr1),
    .mem_data_ram_bus(bus1), .mem_ready(ready1), .busy(busy1), .drop_err(drop1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // called at a negedge; leaves the bench at the negedge after the accepting edge
  task automatic do_write(input logic [9:0] a, input logic [19:0] d);
    req = 1'b1; rw = 1'b1; addr = a; drv = d; drv_en = 1'b1;
    @(posedge clk);
    model[a[9:1]] = d;
    @(negedge clk);
    check("wr_ready", ready, 0);
    check("wr_busy", busy, 0);
    req = 1'b0; rw = 1'b0; drv_en = 1'b0;
  endtask
  task automatic do_read(input logic [9:0] a, input bit coll);
    req = 1'b1; rw = 1'b0; addr = a;
    @(posedge clk);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check("rd_wait_ready", ready, 0);
      check("rd_wait_busy", busy, 1);
      check("rd_drop", drop, 32'(coll && i == 1));
      if (coll && i == 0) begin
        rw = 1'b1; drv = 20'($urandom); drv_en = 1'b1;
      end
      if (coll && i == 1) begin
        rw = 1'b0; drv_en = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("rd_ready", ready, 1);
    check("rd_data", bus, model[a[9:1]]);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("rd_after_ready", ready, 0);
    check("rd_after_drop", drop, 0);
    check("rd_after_busy", busy, 0);
  endtask
  task automatic do_read1(input logic [9:0] a, input logic [19:0] exp);
    req1 = 1'b1; rw1 = 1'b0; addr1 = a;
    @(posedge clk);
    @(negedge clk);
    check("l1_wait_ready", ready1, 0);
    check("l1_wait_busy", busy1, 1);
    @(posedge clk);
    @(negedge clk);
    check("l1_ready", ready1, 1);
    check("l1_data", bus1, exp);
    check("l1_drop", drop1, 0);
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    check("l1_after_ready", ready1, 0);
    check("l1_after_drop", drop1, 0);
    @(negedge clk);
    check("l1_single_resp", ready1, 0);
  endtask
  initial begin
    logic [19:0] d;
    logic [9:0] a;
    for (int b = 0; b < 512; b++) model[b] = {10'(2 * b + 1), 10'(2 * b)};
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(10'd50, 1'b0);
    check("basic_const", model[25], {10'd51, 10'd50});
    do_write(10'd84, 20'h2C12C);
    do_read(10'd85, 1'b0);
    d = 20'($urandom);
    do_write(10'd94, d);
    do_read(10'd223, 1'b0);
    do_read(10'd95, 1'b0);
    do_read(10'd300, 1'b1);
    do_read(10'd300, 1'b0);
    req = 1'b1; rw = 1'b0; addr = 10'd400;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_busy", busy, 0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("mid_no_ready", ready, 0);
    end
    do_read(10'd400, 1'b0);
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      if ($urandom_range(0, 2) == 0) do_write(a, 20'($urandom));
      else do_read(a, $urandom_range(0, 3) == 0);
    end
    do_read1(10'd17, {10'd17, 10'd16});
    req1 = 1'b1; rw1 = 1'b1; addr1 = 10'd600; drv1 = 20'hABCDE; drv_en1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("l1_wr_ready", ready1, 0);
    req1 = 1'b0; rw1 = 1'b0; drv_en1 = 1'b0;
    do_read1(10'd601, 20'hABCDE);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
